// File: rtl/pendigits_pkg.sv
// Shared constants and types for the Pendigits sample sequencer.
// Defaults match the 16-feature, 4-bit classifier instance.
package pendigits_pkg;

   localparam int unsigned INPUT_WIDTH    = 4;
   localparam int unsigned N_FEATURES     = 16;
   localparam int unsigned CLASS_WIDTH    = 4;
   localparam int unsigned MAX_RUN_CYCLES = 512;

   localparam int unsigned FEAT_WIDTH = INPUT_WIDTH * N_FEATURES;
   localparam int unsigned IDX_WIDTH  = $clog2(N_FEATURES);
   localparam int unsigned RUN_WIDTH  = $clog2(MAX_RUN_CYCLES);

   // Class reported when the classifier never answers
   localparam logic [CLASS_WIDTH-1:0] TIMEOUT_CLASS = '1;

   typedef enum logic [1:0] {
      LOAD,
      LAUNCH,
      RUN,
      HOLD
   } seq_state_t;

endpackage

// File: rtl/pendigits_sample_sequencer_if.sv
// Feature input stream and result output handshake of the sample sequencer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface pendigits_sample_sequencer_if ();
   import pendigits_pkg::*;

   logic                   s_valid;
   logic [INPUT_WIDTH-1:0] s_data;
   logic                   s_last;
   logic                   s_ready;

   logic                   m_valid;
   logic [CLASS_WIDTH-1:0] m_class;
   logic                   m_err;
   logic                   m_ready;

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_class, m_err
   );

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_class, m_err
   );

endinterface

// File: rtl/pendigits_sample_sequencer.sv
// Collects one sample of features, runs the sequential SVM classifier on it
// and presents the winning class (or a watchdog timeout) downstream.
module pendigits_sample_sequencer
   import pendigits_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   pendigits_sample_sequencer_if.slave   bus,
   output logic [FEAT_WIDTH-1:0]         features,
   output logic                          cls_rst_n,
   input  logic                          cls_ready,
   input  logic [CLASS_WIDTH-1:0]        cls_class,
   output logic                          frame_err
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_FEATURES - 1);
   localparam logic [RUN_WIDTH-1:0] RUN_MAX  = RUN_WIDTH'(MAX_RUN_CYCLES - 1);

   seq_state_t             state_q,     state_d;
   logic [IDX_WIDTH-1:0]   idx_q,       idx_d;
   logic [RUN_WIDTH-1:0]   run_q,       run_d;
   logic [FEAT_WIDTH-1:0]  feat_q,      feat_d;
   logic [CLASS_WIDTH-1:0] m_class_q,   m_class_d;
   logic                   m_err_q,     m_err_d;
   logic                   s_ready_q,   s_ready_d;
   logic                   m_valid_q,   m_valid_d;
   logic                   cls_rst_n_q, cls_rst_n_d;
   logic                   frame_err_q, frame_err_d;

   // State register and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= LOAD;
         idx_q       <= '0;
         run_q       <= '0;
         feat_q      <= '0;
         m_class_q   <= '0;
         m_err_q     <= 1'b0;
         s_ready_q   <= 1'b1;
         m_valid_q   <= 1'b0;
         cls_rst_n_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         run_q       <= run_d;
         feat_q      <= feat_d;
         m_class_q   <= m_class_d;
         m_err_q     <= m_err_d;
         s_ready_q   <= s_ready_d;
         m_valid_q   <= m_valid_d;
         cls_rst_n_q <= cls_rst_n_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next-state, counters, feature capture and result capture
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      run_d       = run_q;
      feat_d      = feat_q;
      m_class_d   = m_class_q;
      m_err_d     = m_err_q;
      frame_err_d = 1'b0;

      case (state_q)
         LOAD: begin
            if (bus.s_valid) begin
               feat_d[32'(idx_q) * INPUT_WIDTH +: INPUT_WIDTH] = bus.s_data;
               if (bus.s_last && (idx_q == LAST_IDX)) begin
                  state_d = LAUNCH;
                  idx_d   = '0;
               end else if (bus.s_last || (idx_q == LAST_IDX)) begin
                  frame_err_d = 1'b1;
                  idx_d       = '0;
               end else begin
                  idx_d = idx_q + IDX_WIDTH'(1);
               end
            end
         end
         LAUNCH: begin
            state_d = RUN;
            run_d   = '0;
         end
         RUN: begin
            if (run_q != RUN_MAX) begin
               run_d = run_q + RUN_WIDTH'(1);
            end
            // The first RUN cycle still sees the classifier in reset
            if ((run_q != '0) && cls_ready) begin
               m_class_d = cls_class;
               m_err_d   = 1'b0;
               state_d   = HOLD;
            end else if (run_q == RUN_MAX) begin
               m_class_d = TIMEOUT_CLASS;
               m_err_d   = 1'b1;
               state_d   = HOLD;
            end
         end
         HOLD: begin
            if (bus.m_ready) begin
               state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase

      s_ready_d   = (state_d == LOAD);
      m_valid_d   = (state_d == HOLD);
      // Classifier leaves reset one cycle after LAUNCH and re-enters it when the result is taken
      cls_rst_n_d = ((state_q == RUN) || (state_q == HOLD)) && (state_d != LOAD);
   end

   assign features    = feat_q;
   assign cls_rst_n   = cls_rst_n_q;
   assign frame_err   = frame_err_q;
   assign bus.s_ready = s_ready_q;
   assign bus.m_valid = m_valid_q;
   assign bus.m_class = m_class_q;
   assign bus.m_err   = m_err_q;

endmodule

// File: tb/tb_pendigits_sample_sequencer.sv
// Scoreboard bench for pendigits_sample_sequencer: directed scenarios plus
// randomized samples, a behavioural classifier and a decoupled result monitor.
module tb_pendigits_sample_sequencer;
   import pendigits_pkg::*;

   typedef struct packed {
      logic [CLASS_WIDTH-1:0] cls;
      logic                   err;
   } res_t;

   logic                   clk;
   logic                   rst;
   logic [FEAT_WIDTH-1:0]  features;
   logic                   cls_rst_n;
   logic                   cls_ready;
   logic [CLASS_WIDTH-1:0] cls_class;
   logic                   frame_err;

   pendigits_sample_sequencer_if bus ();

   pendigits_sample_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .features  (features),
      .cls_rst_n (cls_rst_n),
      .cls_ready (cls_ready),
      .cls_class (cls_class),
      .frame_err (frame_err)
   );

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];

   int                     m_delay = 0;
   logic [CLASS_WIDTH-1:0] m_cls   = '0;
   int                     ready_mode = 1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Classifier model: answers m_cls once it has been out of reset for m_delay cycles
   int cyc = 0;
   always @(negedge clk) begin
      if (cls_rst_n !== 1'b1) begin
         cyc       = 0;
         cls_ready = 1'b0;
      end else begin
         cyc++;
         cls_ready = (m_delay > 0) && (cyc >= m_delay);
      end
      cls_class = m_cls;
   end

   // Consumer: 0 = random acceptance, 1 = hold off, 2 = always accept
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       bus.m_ready = ($urandom_range(0, 99) < 60);
         1:       bus.m_ready = 1'b0;
         default: bus.m_ready = 1'b1;
      endcase
   end

   // Result monitor
   bit                     prev_stall = 0;
   logic [CLASS_WIDTH-1:0] prev_cls;
   logic                   prev_err;
   always @(negedge clk) begin
      #1;
      if (rst) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 64'(bus.m_valid), 64'(1));
            chk("hold_class", 64'(bus.m_class), 64'(prev_cls));
            chk("hold_err", 64'(bus.m_err), 64'(prev_err));
         end
         if (bus.m_valid) begin
            chk("s_ready_in_hold", 64'(bus.s_ready), 64'(0));
            if (bus.m_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: got class 0x%0h err %0b, expected none", bus.m_class, bus.m_err);
               end else begin
                  res_t r;
                  r = exp_q.pop_front();
                  chk("result_class", 64'(bus.m_class), 64'(r.cls));
                  chk("result_err", 64'(bus.m_err), 64'(r.err));
               end
            end
         end
         prev_stall = (bus.m_valid === 1'b1) && (bus.m_ready !== 1'b1);
         prev_cls   = bus.m_class;
         prev_err   = bus.m_err;
      end
   end

   // Present one beat starting at a negedge; returns at the negedge after it transfers
   task automatic drive_beat(input logic [INPUT_WIDTH-1:0] d, input bit last);
      int budget = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = last;
      while (bus.s_ready !== 1'b1 && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      if (bus.s_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL beat_accept: got s_ready %b, expected 1 within 2000 cycles", bus.s_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   // last_pos = 15 is well formed; < 15 ends early; -1 sends 16 beats without s_last
   task automatic send_sample(input logic [INPUT_WIDTH-1:0] dat [N_FEATURES], input int last_pos,
                              input int delay, input logic [CLASS_WIDTH-1:0] cls);
      int                    n;
      logic [FEAT_WIDTH-1:0] exp_feat;
      res_t                  r;
      n = (last_pos >= 0) ? last_pos + 1 : N_FEATURES;
      exp_feat = '0;
      for (int k = 0; k < N_FEATURES; k++) begin
         exp_feat[k*INPUT_WIDTH +: INPUT_WIDTH] = dat[k];
      end
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 1)) @(negedge clk);
         drive_beat(dat[k], k == last_pos);
      end
      m_delay = delay;
      m_cls   = cls;
      if (last_pos == N_FEATURES - 1) begin
         r.err = (delay <= 0) || (delay >= int'(MAX_RUN_CYCLES));
         r.cls = r.err ? 4'hF : cls;
         exp_q.push_back(r);
         chk("launch_features", features, exp_feat);
         chk("launch_cls_rst_n", 64'(cls_rst_n), 64'(0));
         chk("launch_s_ready", 64'(bus.s_ready), 64'(0));
         repeat (2) @(negedge clk);
         chk("run_cls_rst_n", 64'(cls_rst_n), 64'(1));
      end else begin
         chk("frame_err_pulse", 64'(frame_err), 64'(1));
         chk("frame_cls_rst_n", 64'(cls_rst_n), 64'(0));
         @(negedge clk);
         chk("frame_err_clear", 64'(frame_err), 64'(0));
         chk("frame_no_launch", 64'(cls_rst_n), 64'(0));
         chk("frame_s_ready", 64'(bus.s_ready), 64'(1));
      end
   endtask

   task automatic drain();
      int b = 0;
      while (exp_q.size() != 0 && b < 3000) begin
         @(negedge clk);
         b++;
      end
      chk("drain", 64'(exp_q.size()), 64'(0));
   endtask

   logic [INPUT_WIDTH-1:0] dat [N_FEATURES];

   initial begin
      rst         = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_state", 64'(dut.state_q), 64'(LOAD));
      chk("rst_s_ready", 64'(bus.s_ready), 64'(1));
      chk("rst_cls_rst_n", 64'(cls_rst_n), 64'(0));
      chk("rst_features", features, 64'(0));
      chk("rst_m_valid", 64'(bus.m_valid), 64'(0));
      chk("rst_m_class", 64'(bus.m_class), 64'(0));
      chk("rst_m_err", 64'(bus.m_err), 64'(0));
      chk("rst_frame_err", 64'(frame_err), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Basic sample 0..15, class 7 after 40 cycles, consumer stalled
      for (int k = 0; k < N_FEATURES; k++) dat[k] = INPUT_WIDTH'(k);
      ready_mode = 1;
      send_sample(dat, 15, 40, 4'd7);
      chk("basic_features", features, 64'hFEDCBA9876543210);
      begin
         int b = 0;
         while (bus.m_valid !== 1'b1 && b < 200) begin
            @(negedge clk);
            b++;
         end
      end
      repeat (10) begin
         chk("bp_m_valid", 64'(bus.m_valid), 64'(1));
         chk("bp_m_class", 64'(bus.m_class), 64'(7));
         chk("bp_m_err", 64'(bus.m_err), 64'(0));
         chk("bp_s_ready", 64'(bus.s_ready), 64'(0));
         chk("bp_features", features, 64'hFEDCBA9876543210);
         @(negedge clk);
      end
      ready_mode = 2;
      @(negedge clk);
      @(negedge clk);
      chk("release_s_ready", 64'(bus.s_ready), 64'(1));
      chk("release_m_valid", 64'(bus.m_valid), 64'(0));
      ready_mode = 0;
      drain();

      // Framing errors, then a good sample
      for (int k = 0; k < N_FEATURES; k++) dat[k] = INPUT_WIDTH'($urandom_range(0, 15));
      send_sample(dat, 5, 10, 4'd2);
      send_sample(dat, -1, 10, 4'd2);
      for (int k = 0; k < N_FEATURES; k++) dat[k] = INPUT_WIDTH'($urandom_range(0, 15));
      send_sample(dat, 15, 12, 4'd9);
      drain();

      // Watchdog timeout with exact 512-cycle boundary
      ready_mode = 1;
      send_sample(dat, 15, -1, 4'd4);
      repeat (510) @(negedge clk);
      chk("wd_not_yet", 64'(bus.m_valid), 64'(0));
      @(negedge clk);
      chk("wd_m_valid", 64'(bus.m_valid), 64'(1));
      chk("wd_m_class", 64'(bus.m_class), 64'hF);
      chk("wd_m_err", 64'(bus.m_err), 64'(1));
      ready_mode = 0;
      drain();

      // Ready in the same cycle as the timeout
      send_sample(dat, 15, 511, 4'd3);
      drain();

      // Reset twenty cycles into RUN
      for (int k = 0; k < N_FEATURES; k++) dat[k] = INPUT_WIDTH'($urandom_range(1, 15));
      send_sample(dat, 15, -1, 4'd5);
      repeat (18) @(negedge clk);
      rst = 1'b1;
      #1;
      exp_q.delete();
      chk("mid_rst_state", 64'(dut.state_q), 64'(LOAD));
      chk("mid_rst_cls_rst_n", 64'(cls_rst_n), 64'(0));
      chk("mid_rst_m_valid", 64'(bus.m_valid), 64'(0));
      chk("mid_rst_features", features, 64'(0));
      chk("mid_rst_s_ready", 64'(bus.s_ready), 64'(1));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_s_ready", 64'(bus.s_ready), 64'(1));

      // Randomized samples
      for (int i = 0; i < 14; i++) begin
         int kind;
         kind = $urandom_range(0, 9);
         for (int k = 0; k < N_FEATURES; k++) dat[k] = INPUT_WIDTH'($urandom_range(0, 15));
         if (kind == 0)
            send_sample(dat, $urandom_range(0, 14), 5, 4'd1);
         else if (kind == 1)
            send_sample(dat, -1, 5, 4'd1);
         else
            send_sample(dat, 15, $urandom_range(1, 120), CLASS_WIDTH'($urandom_range(0, 15)));
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
